fram_req_arbiter: RTL and testbench



---
 rtl/fram_req_arbiter.sv | 240 ++++++++++++++++++++++++
 tb/tb_fram_req_arbiter.sv | 400 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fram_req_arbiter.sv
// Round-robin arbiter sharing one FRAM access driver among NUM_REQ requesters:
// holds each command for the whole access, returns read data or a watchdog error.
module fram_req_arbiter #(
    parameter int NUM_REQ        = 2,
    parameter int TIMEOUT_CYCLES = 4096,
    parameter int SETTLE_CYCLES  = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NUM_REQ-1:0]    req_valid,
    input  logic [NUM_REQ-1:0]    req_write,
    input  logic [NUM_REQ*11-1:0] req_addr,
    input  logic [NUM_REQ*32-1:0] req_wdata,
    output logic [NUM_REQ-1:0]    req_ready,
    output logic [NUM_REQ-1:0]    rsp_valid,
    output logic [31:0]           rsp_rdata,
    output logic                  rsp_err,
    output logic                  drv_start,
    output logic [10:0]           drv_addr,
    output logic [31:0]           drv_wdata,
    output logic                  drv_we,
    output logic                  drv_re,
    input  logic [31:0]           drv_rdata,
    input  logic                  drv_rvalid,
    input  logic                  drv_done,
    output logic [2:0]            grant_id,
    output logic                  active
);
    localparam int               CNT_W       = $clog2(TIMEOUT_CYCLES);
    localparam logic [CNT_W-1:0] TMO_LAST    = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [3:0]       SETTLE_LAST = 4'((SETTLE_CYCLES > 0) ? SETTLE_CYCLES - 1 : 0);

    typedef enum logic [2:0] {
        ST_ARB    = 3'd0,
        ST_ISSUE  = 3'd1,
        ST_WAIT   = 3'd2,
        ST_RESP   = 3'd3,
        ST_SETTLE = 3'd4
    } state_t;

    state_t             state_r;
    logic [2:0]         ptr_r;
    logic [2:0]         grant_r;
    logic [CNT_W-1:0]   tmo_cnt_r;
    logic [3:0]         settle_cnt_r;
    logic [31:0]        rdata_r;
    logic               drv_start_r;
    logic [10:0]        drv_addr_r;
    logic [31:0]        drv_wdata_r;
    logic               drv_we_r;
    logic               drv_re_r;
    logic               active_r;
    logic [NUM_REQ-1:0] rsp_valid_r;
    logic [31:0]        rsp_rdata_r;
    logic               rsp_err_r;

    logic [7:0]         valid_pad_s;
    logic [7:0]         write_pad_s;
    logic [10:0]        addr_arr_s [0:7];
    logic [31:0]        wdata_arr_s [0:7];
    logic               hit_s;
    logic [2:0]         hit_idx_s;
    logic [NUM_REQ-1:0] grant_oh_s;
    logic               timeout_s;

    function automatic logic [2:0] rr_next(input logic [2:0] idx);
        logic [2:0] nxt;
        if (idx == 3'(NUM_REQ - 1)) begin
            nxt = 3'd0;
        end else begin
            nxt = idx + 3'd1;
        end
        return nxt;
    endfunction

    // Widen requester-indexed inputs to 8 entries so a 3-bit index selects exactly.
    always_comb begin
        valid_pad_s = 8'd0;
        write_pad_s = 8'd0;
        for (int i = 0; i < 8; i++) begin
            addr_arr_s[i]  = 11'd0;
            wdata_arr_s[i] = 32'd0;
        end
        for (int i = 0; i < NUM_REQ; i++) begin
            valid_pad_s[i] = req_valid[i];
            write_pad_s[i] = req_write[i];
            addr_arr_s[i]  = req_addr[i*11 +: 11];
            wdata_arr_s[i] = req_wdata[i*32 +: 32];
        end
    end

    // Round-robin search starting at ptr_r and wrapping; first valid requester wins.
    always_comb begin : rr_search
        logic [3:0] sum_v;
        sum_v     = 4'd0;
        hit_s     = 1'b0;
        hit_idx_s = 3'd0;
        for (int i = 0; i < NUM_REQ; i++) begin
            sum_v = {1'b0, ptr_r} + 4'(i);
            if (sum_v >= 4'(NUM_REQ)) begin
                sum_v = sum_v - 4'(NUM_REQ);
            end else begin
                sum_v = sum_v;
            end
            if (!hit_s && valid_pad_s[sum_v[2:0]]) begin
                hit_s     = 1'b1;
                hit_idx_s = sum_v[2:0];
            end else begin
                hit_s = hit_s;
            end
        end
    end

    // Accept pulse is combinational so a request seen in ARB is taken that same cycle.
    always_comb begin
        req_ready  = '0;
        grant_oh_s = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if ((state_r == ST_ARB) && !rst && hit_s && (hit_idx_s == 3'(i))) begin
                req_ready[i] = 1'b1;
            end else begin
                req_ready[i] = 1'b0;
            end
            grant_oh_s[i] = (grant_r == 3'(i));
        end
    end

    assign timeout_s = (tmo_cnt_r == TMO_LAST);

    // Access sequencer; the counter runs from drv_start so the watchdog fires TIMEOUT_CYCLES later.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r      <= ST_ARB;
            ptr_r        <= 3'd0;
            grant_r      <= 3'd0;
            tmo_cnt_r    <= '0;
            settle_cnt_r <= 4'd0;
            rdata_r      <= 32'd0;
            drv_start_r  <= 1'b0;
            drv_addr_r   <= 11'd0;
            drv_wdata_r  <= 32'd0;
            drv_we_r     <= 1'b0;
            drv_re_r     <= 1'b0;
            active_r     <= 1'b0;
            rsp_valid_r  <= '0;
            rsp_rdata_r  <= 32'd0;
            rsp_err_r    <= 1'b0;
        end else begin
            drv_start_r <= 1'b0;
            case (state_r)
                ST_ARB: begin
                    if (hit_s) begin
                        grant_r     <= hit_idx_s;
                        ptr_r       <= rr_next(hit_idx_s);
                        drv_addr_r  <= addr_arr_s[hit_idx_s];
                        drv_wdata_r <= wdata_arr_s[hit_idx_s];
                        drv_we_r    <= write_pad_s[hit_idx_s];
                        drv_re_r    <= ~write_pad_s[hit_idx_s];
                        drv_start_r <= 1'b1;
                        active_r    <= 1'b1;
                        tmo_cnt_r   <= '0;
                        rdata_r     <= 32'd0;
                        state_r     <= ST_ISSUE;
                    end else begin
                        state_r <= ST_ARB;
                    end
                end
                ST_ISSUE: begin
                    tmo_cnt_r <= tmo_cnt_r + CNT_W'(1);
                    state_r   <= ST_WAIT;
                end
                ST_WAIT: begin
                    tmo_cnt_r <= tmo_cnt_r + CNT_W'(1);
                    if (drv_rvalid) begin
                        rdata_r <= drv_rdata;
                    end else begin
                        rdata_r <= rdata_r;
                    end
                    if (drv_done || timeout_s) begin
                        rsp_valid_r <= grant_oh_s;
                        rsp_err_r   <= ~drv_done;
                        if (drv_done && !drv_we_r) begin
                            rsp_rdata_r <= drv_rvalid ? drv_rdata : rdata_r;
                        end else begin
                            rsp_rdata_r <= 32'd0;
                        end
                        drv_addr_r  <= 11'd0;
                        drv_wdata_r <= 32'd0;
                        drv_we_r    <= 1'b0;
                        drv_re_r    <= 1'b0;
                        active_r    <= 1'b0;
                        state_r     <= ST_RESP;
                    end else begin
                        state_r <= ST_WAIT;
                    end
                end
                ST_RESP: begin
                    rsp_valid_r  <= '0;
                    rsp_rdata_r  <= 32'd0;
                    rsp_err_r    <= 1'b0;
                    settle_cnt_r <= 4'd0;
                    if (SETTLE_CYCLES == 0) begin
                        state_r <= ST_ARB;
                    end else begin
                        state_r <= ST_SETTLE;
                    end
                end
                ST_SETTLE: begin
                    if (settle_cnt_r == SETTLE_LAST) begin
                        state_r <= ST_ARB;
                    end else begin
                        settle_cnt_r <= settle_cnt_r + 4'd1;
                        state_r      <= ST_SETTLE;
                    end
                end
                default: begin
                    drv_addr_r  <= 11'd0;
                    drv_wdata_r <= 32'd0;
                    drv_we_r    <= 1'b0;
                    drv_re_r    <= 1'b0;
                    active_r    <= 1'b0;
                    rsp_valid_r <= '0;
                    state_r     <= ST_ARB;
                end
            endcase
        end
    end

    assign drv_start = drv_start_r;
    assign drv_addr  = drv_addr_r;
    assign drv_wdata = drv_wdata_r;
    assign drv_we    = drv_we_r;
    assign drv_re    = drv_re_r;
    assign active    = active_r;
    assign grant_id  = grant_r;
    assign rsp_valid = rsp_valid_r;
    assign rsp_rdata = rsp_rdata_r;
    assign rsp_err   = rsp_err_r;

endmodule

// File: tb/tb_fram_req_arbiter.sv
// Scoreboard bench for fram_req_arbiter with a small behavioural FRAM driver model.
module tb_fram_req_arbiter;
    localparam int NUM_REQ        = 2;
    localparam int TIMEOUT_CYCLES = 16;
    localparam int SETTLE_CYCLES  = 2;

    logic                  clk;
    logic                  rst;
    logic [NUM_REQ-1:0]    req_valid, req_write, req_ready, rsp_valid;
    logic [NUM_REQ*11-1:0] req_addr;
    logic [NUM_REQ*32-1:0] req_wdata;
    logic [31:0]           rsp_rdata, drv_wdata, drv_rdata;
    logic                  rsp_err, drv_start, drv_we, drv_re, drv_rvalid, drv_done, active;
    logic [10:0]           drv_addr;
    logic [2:0]            grant_id;

    typedef struct packed {
        logic [2:0]  id;
        logic [31:0] rdata;
        logic        err;
    } rsp_t;

    rsp_t sb[$];
    int   n_checks = 0;
    int   n_errors = 0;
    int   cyc = 0;

    int          m_lat     = 3;
    logic [31:0] m_data    = 32'd0;
    logic        m_give_rv = 1'b0;
    logic        m_stray   = 1'b0;
    logic        m_hang    = 1'b0;

    fram_req_arbiter #(
        .NUM_REQ(NUM_REQ),
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES),
        .SETTLE_CYCLES(SETTLE_CYCLES)
    ) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata),
        .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .drv_start(drv_start), .drv_addr(drv_addr), .drv_wdata(drv_wdata), .drv_we(drv_we),
        .drv_re(drv_re), .drv_rdata(drv_rdata), .drv_rvalid(drv_rvalid), .drv_done(drv_done),
        .grant_id(grant_id), .active(active)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    // Driver model: done m_lat cycles after drv_start; optional stray strobes in ISSUE and first WAIT cycle.
    initial begin : drv_model
        int cnt;
        cnt = 0;
        drv_done = 1'b0;
        drv_rvalid = 1'b0;
        drv_rdata = 32'd0;
        forever begin
            @(negedge clk);
            drv_done = 1'b0;
            drv_rvalid = 1'b0;
            drv_rdata = 32'd0;
            if (rst === 1'b1) begin
                cnt = 0;
            end else if (cnt != 0) begin
                cnt--;
                if (cnt == 0) begin
                    drv_done = ~m_hang;
                    drv_rvalid = m_give_rv;
                    drv_rdata = m_data;
                end else if (m_stray && cnt == m_lat - 1) begin
                    drv_rvalid = 1'b1;
                    drv_rdata = 32'hBAD0_0001;
                end
            end else if (drv_start === 1'b1) begin
                cnt = m_lat;
                if (m_stray) begin
                    drv_rvalid = 1'b1;
                    drv_rdata = 32'hBAD0_0000;
                end
            end
        end
    end

    task automatic test_reset;
        rst = 1'b1;
        req_valid = '0; req_write = '0; req_addr = '0; req_wdata = '0;
        repeat (3) @(negedge clk);
        n_checks++;
        if ({req_ready, rsp_valid, rsp_rdata, rsp_err, drv_start, drv_addr, drv_wdata, drv_we, drv_re, grant_id, active} !== '0) begin
            n_errors++;
            $display("FAIL reset_outputs got %h want 0", {req_ready, rsp_valid, rsp_rdata, rsp_err, drv_start, drv_addr,
                     drv_wdata, drv_we, drv_re, grant_id, active});
        end
        rst = 1'b0;
        repeat (2) @(negedge clk);
        n_checks++;
        if ({drv_start, active, rsp_valid} !== '0) begin
            n_errors++;
            $display("FAIL idle_after_reset got start=%b active=%b rsp=%b want 0", drv_start, active, rsp_valid);
        end
    endtask

    task automatic test_single_read;
        rsp_t e;
        bit   got = 1'b0;
        m_lat = 4; m_data = 32'hDEAD_BEEF; m_give_rv = 1'b1; m_stray = 1'b1; m_hang = 1'b0;
        @(negedge clk);
        req_addr[10:0] = 11'h123; req_write = 2'b00; req_valid = 2'b01;
        sb.push_back('{id: 3'd0, rdata: 32'hDEAD_BEEF, err: 1'b0});
        #1;
        n_checks++;
        if (req_ready !== 2'b01) begin n_errors++; $display("FAIL read_ready got %b want 01", req_ready); end
        @(negedge clk);
        req_valid = 2'b00;
        n_checks++;
        if (drv_start !== 1'b1 || drv_addr !== 11'h123 || drv_re !== 1'b1 || drv_we !== 1'b0 || grant_id !== 3'd0 || active !== 1'b1) begin
            n_errors++;
            $display("FAIL read_issue got start=%b addr=%h re=%b we=%b gid=%0d act=%b want 1 123 1 0 0 1",
                     drv_start, drv_addr, drv_re, drv_we, grant_id, active);
        end
        for (int i = 0; i < 40 && !got; i++) begin
            @(negedge clk);
            if (active === 1'b1) begin
                n_checks++;
                if (drv_start !== 1'b0 || drv_addr !== 11'h123 || drv_re !== 1'b1) begin
                    n_errors++;
                    $display("FAIL read_hold got start=%b addr=%h re=%b want 0 123 1", drv_start, drv_addr, drv_re);
                end
            end
            if (rsp_valid !== '0) begin
                got = 1'b1;
                n_checks++;
                if (sb.size() == 0) begin
                    n_errors++; $display("FAIL read_unexpected_rsp got %b want none", rsp_valid);
                end else begin
                    e = sb.pop_front();
                    if (rsp_valid !== NUM_REQ'(32'd1 << e.id) || rsp_rdata !== e.rdata || rsp_err !== e.err) begin
                        n_errors++;
                        $display("FAIL read_rsp got v=%b d=%h e=%b want v=%b d=%h e=%b", rsp_valid, rsp_rdata, rsp_err,
                                 NUM_REQ'(32'd1 << e.id), e.rdata, e.err);
                    end
                end
            end
        end
        n_checks++;
        if (!got) begin n_errors++; $display("FAIL read_rsp_timeout got none want rsp within 40 cycles"); end
        n_checks++;
        if (drv_addr !== 11'd0 || drv_re !== 1'b0 || active !== 1'b0) begin
            n_errors++; $display("FAIL read_release got addr=%h re=%b act=%b want 0", drv_addr, drv_re, active);
        end
        repeat (SETTLE_CYCLES + 1) @(negedge clk);
    endtask

    task automatic test_single_write;
        rsp_t e;
        bit   got = 1'b0;
        m_lat = 5; m_data = 32'h1234_5678; m_give_rv = 1'b1; m_stray = 1'b0; m_hang = 1'b0;
        @(negedge clk);
        req_addr[21:11] = 11'h7FF; req_wdata[63:32] = 32'hA5A5_0001; req_write = 2'b10; req_valid = 2'b10;
        sb.push_back('{id: 3'd1, rdata: 32'd0, err: 1'b0});
        #1;
        n_checks++;
        if (req_ready !== 2'b10) begin n_errors++; $display("FAIL write_ready got %b want 10", req_ready); end
        @(negedge clk);
        req_valid = 2'b00;
        n_checks++;
        if (drv_start !== 1'b1 || drv_we !== 1'b1 || drv_re !== 1'b0 || drv_addr !== 11'h7FF || grant_id !== 3'd1) begin
            n_errors++;
            $display("FAIL write_issue got start=%b we=%b re=%b addr=%h gid=%0d want 1 1 0 7ff 1",
                     drv_start, drv_we, drv_re, drv_addr, grant_id);
        end
        for (int i = 0; i < 40 && !got; i++) begin
            if (active === 1'b1) begin
                n_checks++;
                if (drv_wdata !== 32'hA5A5_0001 || drv_we !== 1'b1) begin
                    n_errors++; $display("FAIL write_hold got wdata=%h we=%b want a5a50001 1", drv_wdata, drv_we);
                end
            end
            @(negedge clk);
            if (rsp_valid !== '0) begin
                got = 1'b1;
                n_checks++;
                if (sb.size() == 0) begin
                    n_errors++; $display("FAIL write_unexpected_rsp got %b want none", rsp_valid);
                end else begin
                    e = sb.pop_front();
                    if (rsp_valid !== NUM_REQ'(32'd1 << e.id) || rsp_rdata !== e.rdata || rsp_err !== e.err) begin
                        n_errors++;
                        $display("FAIL write_rsp got v=%b d=%h e=%b want v=%b d=%h e=%b", rsp_valid, rsp_rdata, rsp_err,
                                 NUM_REQ'(32'd1 << e.id), e.rdata, e.err);
                    end
                end
            end
        end
        n_checks++;
        if (!got) begin n_errors++; $display("FAIL write_rsp_timeout got none want rsp within 40 cycles"); end
        n_checks++;
        if (drv_wdata !== 32'd0 || drv_we !== 1'b0) begin
            n_errors++; $display("FAIL write_release got wdata=%h we=%b want 0", drv_wdata, drv_we);
        end
        repeat (SETTLE_CYCLES + 1) @(negedge clk);
    endtask

    task automatic test_contention;
        rsp_t e;
        int   n_starts = 0;
        int   n_rsp = 0;
        int   last_rsp = -1;
        bit   outstanding = 1'b0;
        logic [2:0] exp_id;
        m_lat = 3; m_data = 32'd0; m_give_rv = 1'b0; m_stray = 1'b0; m_hang = 1'b0;
        @(negedge clk);
        req_addr = {11'h020, 11'h010}; req_wdata = {32'h1111_0001, 32'h0000_0F00};
        req_write = 2'b11; req_valid = 2'b11;
        for (int k = 0; k < 4; k++) sb.push_back('{id: 3'(k % 2), rdata: 32'd0, err: 1'b0});
        for (int i = 0; i < 200 && n_rsp < 4; i++) begin
            @(negedge clk);
            if (drv_start === 1'b1) begin
                exp_id = 3'(n_starts % 2);
                n_checks++;
                if (grant_id !== exp_id || drv_we !== 1'b1 || drv_addr !== (exp_id == 3'd1 ? 11'h020 : 11'h010) ||
                    drv_wdata !== (exp_id == 3'd1 ? 32'h1111_0001 : 32'h0000_0F00)) begin
                    n_errors++;
                    $display("FAIL cont_grant got gid=%0d addr=%h wdata=%h want gid=%0d", grant_id, drv_addr, drv_wdata, exp_id);
                end
                n_checks++;
                if (outstanding) begin n_errors++; $display("FAIL cont_overlap got 2 outstanding want 1"); end
                if (last_rsp >= 0) begin
                    n_checks++;
                    if (cyc - last_rsp !== 2 + SETTLE_CYCLES) begin
                        n_errors++; $display("FAIL cont_gap got %0d want %0d", cyc - last_rsp, 2 + SETTLE_CYCLES);
                    end
                end
                outstanding = 1'b1;
                n_starts++;
                if (n_starts == 4) req_valid = 2'b00;
            end
            if (rsp_valid !== '0) begin
                n_rsp++;
                outstanding = 1'b0;
                last_rsp = cyc;
                n_checks++;
                if (sb.size() == 0) begin
                    n_errors++; $display("FAIL cont_unexpected_rsp got %b want none", rsp_valid);
                end else begin
                    e = sb.pop_front();
                    if (rsp_valid !== NUM_REQ'(32'd1 << e.id) || rsp_rdata !== e.rdata || rsp_err !== e.err) begin
                        n_errors++;
                        $display("FAIL cont_rsp got v=%b d=%h e=%b want v=%b d=%h e=%b", rsp_valid, rsp_rdata, rsp_err,
                                 NUM_REQ'(32'd1 << e.id), e.rdata, e.err);
                    end
                end
            end
        end
        n_checks++;
        if (n_rsp != 4 || n_starts != 4) begin
            n_errors++; $display("FAIL cont_count got starts=%0d rsps=%0d want 4 4", n_starts, n_rsp);
        end
        repeat (SETTLE_CYCLES + 1) @(negedge clk);
    endtask

    // Shared by the watchdog and coincident cases: both respond exactly TIMEOUT_CYCLES after drv_start.
    task automatic run_timed(input logic [1:0] valid, input string tag);
        rsp_t e;
        int   start_cyc = -1;
        bit   got = 1'b0;
        @(negedge clk);
        req_write = 2'b00; req_valid = valid;
        for (int i = 0; i < 60 && !got; i++) begin
            @(negedge clk);
            if (drv_start === 1'b1) begin
                start_cyc = cyc;
                req_valid = 2'b00;
            end
            if (rsp_valid !== '0) begin
                got = 1'b1;
                n_checks++;
                if (start_cyc < 0 || cyc - start_cyc !== TIMEOUT_CYCLES) begin
                    n_errors++; $display("FAIL %s_latency got %0d want %0d", tag, cyc - start_cyc, TIMEOUT_CYCLES);
                end
                n_checks++;
                if (sb.size() == 0) begin
                    n_errors++; $display("FAIL %s_unexpected_rsp got %b want none", tag, rsp_valid);
                end else begin
                    e = sb.pop_front();
                    if (rsp_valid !== NUM_REQ'(32'd1 << e.id) || rsp_rdata !== e.rdata || rsp_err !== e.err) begin
                        n_errors++;
                        $display("FAIL %s_rsp got v=%b d=%h e=%b want v=%b d=%h e=%b", tag, rsp_valid, rsp_rdata, rsp_err,
                                 NUM_REQ'(32'd1 << e.id), e.rdata, e.err);
                    end
                end
            end
        end
        n_checks++;
        if (!got) begin n_errors++; $display("FAIL %s_rsp_timeout got none want rsp within 60 cycles", tag); end
        repeat (SETTLE_CYCLES + 1) @(negedge clk);
    endtask

    task automatic test_timeout;
        m_lat = 5; m_data = 32'h5555_AAAA; m_give_rv = 1'b1; m_stray = 1'b0; m_hang = 1'b1;
        req_addr[10:0] = 11'h055;
        sb.push_back('{id: 3'd0, rdata: 32'd0, err: 1'b1});
        run_timed(2'b01, "timeout");
    endtask

    task automatic test_coincident;
        m_lat = TIMEOUT_CYCLES - 1; m_data = 32'hCAFE_F00D; m_give_rv = 1'b1; m_stray = 1'b0; m_hang = 1'b0;
        req_addr[21:11] = 11'h3AA;
        sb.push_back('{id: 3'd1, rdata: 32'hCAFE_F00D, err: 1'b0});
        run_timed(2'b10, "coincident");
    endtask

    task automatic test_reset_mid;
        rsp_t e;
        int   n_starts = 0;
        int   n_rsp = 0;
        bit   seen = 1'b0;
        m_lat = 5; m_data = 32'h0; m_give_rv = 1'b0; m_stray = 1'b0; m_hang = 1'b1;
        @(negedge clk);
        req_addr[10:0] = 11'h0AB; req_write = 2'b00; req_valid = 2'b01;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            if (drv_start === 1'b1) seen = 1'b1;
        end
        req_valid = 2'b00;
        n_checks++;
        if (!seen) begin n_errors++; $display("FAIL rstmid_start got none want drv_start"); end
        repeat (3) @(negedge clk);
        rst = 1'b1;
        #1;
        n_checks++;
        if ({req_ready, rsp_valid, rsp_err, drv_start, drv_addr, drv_we, drv_re, grant_id, active} !== '0) begin
            n_errors++;
            $display("FAIL rstmid_async got addr=%h re=%b gid=%0d act=%b want 0", drv_addr, drv_re, grant_id, active);
        end
        repeat (2) begin
            @(negedge clk);
            n_checks++;
            if (rsp_valid !== '0) begin n_errors++; $display("FAIL rstmid_no_rsp got %b want 0", rsp_valid); end
        end
        rst = 1'b0;
        m_lat = 2; m_data = 32'h0BAD_CAFE; m_give_rv = 1'b1; m_hang = 1'b0;
        @(negedge clk);
        req_addr = {11'h111, 11'h0C0}; req_valid = 2'b11;
        sb.push_back('{id: 3'd0, rdata: 32'h0BAD_CAFE, err: 1'b0});
        sb.push_back('{id: 3'd1, rdata: 32'h0BAD_CAFE, err: 1'b0});
        #1;
        n_checks++;
        if (req_ready !== 2'b01) begin n_errors++; $display("FAIL rstmid_ptr got %b want 01", req_ready); end
        for (int i = 0; i < 80 && n_rsp < 2; i++) begin
            @(negedge clk);
            if (drv_start === 1'b1) begin
                n_checks++;
                if (grant_id !== 3'(n_starts) || drv_addr !== (n_starts == 1 ? 11'h111 : 11'h0C0)) begin
                    n_errors++; $display("FAIL rstmid_grant got gid=%0d addr=%h want gid=%0d", grant_id, drv_addr, n_starts);
                end
                req_valid = (n_starts == 0) ? 2'b10 : 2'b00;
                n_starts++;
            end
            if (rsp_valid !== '0) begin
                n_rsp++;
                n_checks++;
                if (sb.size() == 0) begin
                    n_errors++; $display("FAIL rstmid_unexpected_rsp got %b want none", rsp_valid);
                end else begin
                    e = sb.pop_front();
                    if (rsp_valid !== NUM_REQ'(32'd1 << e.id) || rsp_rdata !== e.rdata || rsp_err !== e.err) begin
                        n_errors++;
                        $display("FAIL rstmid_rsp got v=%b d=%h e=%b want v=%b d=%h e=%b", rsp_valid, rsp_rdata, rsp_err,
                                 NUM_REQ'(32'd1 << e.id), e.rdata, e.err);
                    end
                end
            end
        end
        n_checks++;
        if (n_rsp != 2) begin n_errors++; $display("FAIL rstmid_count got %0d want 2", n_rsp); end
    endtask

    initial begin
        rst = 1'b1;
        req_valid = '0; req_write = '0; req_addr = '0; req_wdata = '0;
        test_reset;
        test_single_read;
        test_single_write;
        test_contention;
        test_timeout;
        test_coincident;
        test_reset_mid;
        repeat (4) @(negedge clk);
        n_checks++;
        if (sb.size() != 0) begin n_errors++; $display("FAIL scoreboard_drain got %0d want 0", sb.size()); end
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
